// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding and standard opcode values.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    IDLE             = 4'h1,
    SELECT_DR        = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR        = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } jtag_tap_state_t;

  // Opcodes for the default 4-bit instruction register.
  localparam logic [3:0] JTAG_BYPASS_INST = 4'hF;
  localparam logic [3:0] JTAG_IDCODE_INST = 4'h0;

endpackage

// File: rtl/jtag_tap_controller_synchronizer.sv
// Two-flop synchronizer bringing a bundle of asynchronous pins into clk.
module jtag_tap_controller_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives a settled copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller oversampled in the clk domain.
// Optional feature macro: JTAG_TAP_IDCODE_EN builds the 32-bit IDCODE
// register and makes IDCODE the reset instruction; without it the reset
// instruction is BYPASS and the IDCODE opcode selects the user DR.
// Handshake: capture_dr / shift_dr / update_dr are single-clk strobes with no
// backpressure; data_shift_in is valid in the clk where shift_dr is high, and
// data_shift_out must present the user DR LSB whenever the TAP may sample it.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [31:0]         JTAG_ID     = 32'h4d20dffb,
  parameter logic [IR_WIDTH-1:0] IDCODE_INST = JTAG_IDCODE_INST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                jtag_tck,
  input  logic                jtag_tms,
  input  logic                jtag_tdi,
  input  logic                jtag_trst,
  output logic                jtag_tdo,
  output logic [IR_WIDTH-1:0] instruction,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                data_shift_in,
  input  logic                data_shift_out
);

  // All-ones at any IR width.
  localparam logic [IR_WIDTH-1:0] BYPASS_INST = {IR_WIDTH{JTAG_BYPASS_INST[0]}};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INST  = IDCODE_INST;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INST  = BYPASS_INST;
`endif

  logic [3:0]          sync_q;
  logic                tck_s, tms_s, tdi_s, trst_s;
  logic                tck_prev, tck_rise, tck_fall;
  jtag_tap_state_t     state, state_next;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic                is_bypass, is_idcode, user_sel;
  logic                idcode_lsb, dr_lsb;

  jtag_tap_controller_synchronizer #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({jtag_trst, jtag_tdi, jtag_tms, jtag_tck}),
    .q     (sync_q)
  );

  assign {trst_s, tdi_s, tms_s, tck_s} = sync_q;
  assign tck_rise      = tck_s & ~tck_prev;
  assign tck_fall      = ~tck_s & tck_prev;
  assign data_shift_in = tdi_s;

  // Delayed tck copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tck_prev <= 1'b0;
    else       tck_prev <= tck_s;
  end

  // TAP state register: advances only on a detected tck rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state <= TEST_LOGIC_RESET;
    else if (trst_s)   state <= TEST_LOGIC_RESET;
    else if (tck_rise) state <= state_next;
  end

  // Standard 1149.1 transition graph keyed by synchronized tms.
  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms_s ? TEST_LOGIC_RESET : IDLE;
      IDLE:             state_next = tms_s ? SELECT_DR : IDLE;
      SELECT_DR:        state_next = tms_s ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         state_next = tms_s ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         state_next = tms_s ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         state_next = tms_s ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         state_next = tms_s ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        state_next = tms_s ? SELECT_DR : IDLE;
      SELECT_IR:        state_next = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         state_next = tms_s ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         state_next = tms_s ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         state_next = tms_s ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         state_next = tms_s ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        state_next = tms_s ? SELECT_DR : IDLE;
      default:          state_next = TEST_LOGIC_RESET;
    endcase
  end

  // User DR strobes: capture/shift on the rising edge in the state, update on
  // the falling edge in UPDATE_DR; they live in different states so they can
  // never overlap, and tck edges last one clk so each strobe is one clk wide.
  always_comb begin
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    if (user_sel && !trst_s) begin
      capture_dr = tck_rise && (state == CAPTURE_DR);
      shift_dr   = tck_rise && (state == SHIFT_DR);
      update_dr  = tck_fall && (state == UPDATE_DR);
    end
  end

  assign is_bypass = (instruction == BYPASS_INST);
  assign user_sel  = !is_bypass && !is_idcode;

  // IR capture/shift on rising edges; instruction committed on the falling
  // edge in UPDATE_IR and pinned to the reset opcode while in reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_shift    <= '0;
      instruction <= RESET_INST;
    end else if (trst_s) begin
      ir_shift    <= '0;
      instruction <= RESET_INST;
    end else begin
      if (tck_rise && state == CAPTURE_IR)
        ir_shift <= IR_CAPTURE;
      else if (tck_rise && state == SHIFT_IR)
        ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
      if (state == TEST_LOGIC_RESET)
        instruction <= RESET_INST;
      else if (tck_fall && state == UPDATE_IR)
        instruction <= ir_shift;
    end
  end

  // One-bit BYPASS register: captures 0, then acts as a single-stage delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        bypass_reg <= 1'b0;
    else if (trst_s)                                  bypass_reg <= 1'b0;
    else if (tck_rise && is_bypass && state == CAPTURE_DR) bypass_reg <= 1'b0;
    else if (tck_rise && is_bypass && state == SHIFT_DR)   bypass_reg <= tdi_s;
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_reg;

  assign is_idcode  = !is_bypass && (instruction == IDCODE_INST);
  assign idcode_lsb = idcode_reg[0];

  // IDCODE register: captures the device ID, shifts right with tdi at MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             idcode_reg <= '0;
    else if (trst_s)                                       idcode_reg <= '0;
    else if (tck_rise && is_idcode && state == CAPTURE_DR) idcode_reg <= JTAG_ID;
    else if (tck_rise && is_idcode && state == SHIFT_DR)   idcode_reg <= {tdi_s, idcode_reg[31:1]};
  end
`else
  logic unused_idcode_params;

  assign is_idcode            = 1'b0;
  assign idcode_lsb           = 1'b0;
  assign unused_idcode_params = ^{JTAG_ID, IDCODE_INST};
`endif

  assign dr_lsb = is_bypass ? bypass_reg : (is_idcode ? idcode_lsb : data_shift_out);

  // tdo changes only on falling tck edges so the host sees it stable on rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         jtag_tdo <= 1'b0;
    else if (trst_s)   jtag_tdo <= 1'b0;
    else if (tck_fall) begin
      if (state == SHIFT_IR)      jtag_tdo <= ir_shift[0];
      else if (state == SHIFT_DR) jtag_tdo <= dr_lsb;
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller (either JTAG_TAP_IDCODE_EN build).
`timescale 1ns/1ps
module tb_jtag_tap_controller;
  import jtag_pkg::*;

`ifdef JTAG_TAP_IDCODE_EN
  localparam bit IDCODE_EN = 1'b1;
`else
  localparam bit IDCODE_EN = 1'b0;
`endif
  localparam logic [3:0]  RESET_INST   = IDCODE_EN ? JTAG_IDCODE_INST : JTAG_BYPASS_INST;
  localparam logic [31:0] DEVICE_ID    = 32'h4d20dffb;
  localparam logic [7:0]  USER_CAPTURE = 8'h3C;
  localparam int          USER_LEN     = 8;
  localparam int          HALF         = 6;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, jtag_tck, jtag_tms, jtag_tdi, jtag_trst, jtag_tdo;
  logic capture_dr, shift_dr, update_dr, data_shift_in, data_shift_out;
  logic [3:0] instruction;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_tap_controller #(
    .IR_WIDTH    (4),
    .JTAG_ID     (DEVICE_ID),
    .IDCODE_INST (4'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .jtag_tck       (jtag_tck),
    .jtag_tms       (jtag_tms),
    .jtag_tdi       (jtag_tdi),
    .jtag_trst      (jtag_trst),
    .jtag_tdo       (jtag_tdo),
    .instruction    (instruction),
    .capture_dr     (capture_dr),
    .shift_dr       (shift_dr),
    .update_dr      (update_dr),
    .data_shift_in  (data_shift_in),
    .data_shift_out (data_shift_out)
  );

  // ---------------- user DR stand-in and strobe monitor ----------------
  logic [7:0] user_dr = 8'h00;
  int n_cap = 0, n_shift = 0, n_upd = 0, n_excl = 0, n_wide = 0;
  logic prev_cap = 1'b0, prev_shift = 1'b0, prev_upd = 1'b0;
  logic dsi_q[$];

  assign data_shift_out = user_dr[0];

  always @(negedge clk) begin
    if (capture_dr) user_dr = USER_CAPTURE;
    else if (shift_dr) user_dr = {data_shift_in, user_dr[7:1]};
    if (capture_dr) n_cap++;
    if (shift_dr) begin n_shift++; dsi_q.push_back(data_shift_in); end
    if (update_dr) n_upd++;
    if (int'(capture_dr) + int'(shift_dr) + int'(update_dr) > 1) n_excl++;
    if ((capture_dr && prev_cap) || (shift_dr && prev_shift) || (update_dr && prev_upd)) n_wide++;
    prev_cap = capture_dr; prev_shift = shift_dr; prev_upd = update_dr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_inst;

  function automatic int dr_len(input logic [3:0] inst);
    if (inst == JTAG_BYPASS_INST) return 1;
    if (IDCODE_EN && inst == JTAG_IDCODE_INST) return 32;
    return USER_LEN;
  endfunction

  function automatic logic [63:0] dr_cap(input logic [3:0] inst);
    if (inst == JTAG_BYPASS_INST) return 64'd0;
    if (IDCODE_EN && inst == JTAG_IDCODE_INST) return 64'(DEVICE_ID);
    return 64'(USER_CAPTURE);
  endfunction

  function automatic bit is_user(input logic [3:0] inst);
    return dr_len(inst) == USER_LEN;
  endfunction

  // A shift register seen as a FIFO of bits: LSB leaves, tdi joins at MSB.
  task automatic model_shift(input logic [63:0] cap, input int n, input int len,
                             input logic [63:0] tdi, output logic [63:0] out_bits,
                             output logic [63:0] final_reg);
    logic q[$];
    out_bits  = '0;
    final_reg = '0;
    for (int k = 0; k < n; k++) q.push_back(cap[k]);
    for (int i = 0; i < len; i++) begin
      out_bits[i] = q.pop_front();
      q.push_back(tdi[i]);
    end
    for (int k = 0; k < n; k++) final_reg[k] = q[k];
  endtask

  function automatic logic [63:0] len_mask(input int len);
    return (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    jtag_tms = tms_v;
    jtag_tdi = tdi_v;
    repeat (HALF) @(negedge clk);
    tdo_v = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  task automatic tck_tms(input logic tms_v);
    logic d;
    tck_cycle(tms_v, $urandom_range(0, 1) != 0, d);
  endtask

  // IDLE -> scan -> IDLE, optionally detouring through PAUSE after bit pause_at.
  task automatic scan(input bit is_ir, input int len, input logic [63:0] tdi_bits,
                      input int pause_at, output logic [63:0] tdo_bits);
    logic d;
    bit last, pz;
    tdo_bits = '0;
    tck_tms(1'b1);
    if (is_ir) tck_tms(1'b1);
    tck_tms(1'b0);
    tck_tms(1'b0);
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      pz   = (i == pause_at) && !last;
      tck_cycle(last || pz, tdi_bits[i], d);
      tdo_bits[i] = d;
      if (pz) begin
        repeat ($urandom_range(1, 4)) tck_tms(1'b0);
        tck_tms(1'b1);
        tck_tms(1'b0);
      end
    end
    tck_tms(1'b1);
    tck_tms(1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_ir(input string name, input logic [3:0] val, input int pause_at,
                       output logic [3:0] tdo4);
    logic [63:0] t, e, f;
    int c0, s0, u0;
    c0 = n_cap; s0 = n_shift; u0 = n_upd;
    scan(1'b1, 4, 64'(val), pause_at, t);
    model_shift(64'(4'b0001), 4, 4, 64'(val), e, f);
    tdo4 = t[3:0];
    check({name, "_ir_tdo"}, 64'(t[3:0]), 64'(e[3:0]));
    check({name, "_instruction"}, 64'(instruction), 64'(f[3:0]));
    check({name, "_ir_no_dr_strobes"}, 64'((n_cap - c0) + (n_shift - s0) + (n_upd - u0)), 64'd0);
    m_inst = f[3:0];
  endtask

  task automatic do_dr(input string name, input int len, input logic [63:0] tdi_bits,
                       input int pause_at, output logic [63:0] tdo_bits);
    logic [63:0] e, f, dsi, mask;
    int c0, s0, u0, d0;
    bit user;
    c0 = n_cap; s0 = n_shift; u0 = n_upd; d0 = dsi_q.size();
    user = is_user(m_inst);
    mask = len_mask(len);
    scan(1'b0, len, tdi_bits, pause_at, tdo_bits);
    model_shift(dr_cap(m_inst), dr_len(m_inst), len, tdi_bits, e, f);
    check({name, "_dr_tdo"}, tdo_bits & mask, e & mask);
    check({name, "_capture_cnt"}, 64'(n_cap - c0), user ? 64'd1 : 64'd0);
    check({name, "_shift_cnt"}, 64'(n_shift - s0), user ? 64'(len) : 64'd0);
    check({name, "_update_cnt"}, 64'(n_upd - u0), user ? 64'd1 : 64'd0);
    if (user) begin
      dsi = '0;
      for (int k = 0; k < len && (d0 + k) < dsi_q.size(); k++) dsi[k] = dsi_q[d0 + k];
      check({name, "_data_shift_in"}, dsi, tdi_bits & mask);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  ir_in;
    int          len;
    logic [31:0] dr_tdi;
    logic [3:0]  exp_ir_tdo;
    logic [31:0] exp_dr_tdo;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  t4;
    logic [63:0] t64;
    int          len, pause, c0, u0;
    logic [3:0]  ir_val;

    reset = 1'b1; jtag_tck = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; jtag_trst = 1'b0;
    m_inst = RESET_INST;

    vecs[0] = '{ir_in: 4'hF, len: 5,  dr_tdi: 32'h0000000D, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h0000001A};
    vecs[1] = '{ir_in: 4'h3, len: 8,  dr_tdi: 32'h000000A5, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h0000003C};
    vecs[2] = '{ir_in: 4'hF, len: 3,  dr_tdi: 32'h00000007, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h00000006};
    vecs[3] = '{ir_in: 4'h5, len: 12, dr_tdi: 32'h00000ABC, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h00000C3C};
`ifdef JTAG_TAP_IDCODE_EN
    vecs[4] = '{ir_in: 4'h0, len: 32, dr_tdi: 32'h00000000, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h4d20dffb};
`else
    vecs[4] = '{ir_in: 4'h0, len: 8,  dr_tdi: 32'h00000000, exp_ir_tdo: 4'b0001, exp_dr_tdo: 32'h0000003C};
`endif

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state.
    check("reset_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("reset_instruction", 64'(instruction), 64'(RESET_INST));
    check("reset_tdo", 64'(jtag_tdo), 64'd0);
    check("reset_strobes", 64'(n_cap + n_shift + n_upd), 64'd0);

    // tms=1 x5 from SHIFT_DR returns to TEST_LOGIC_RESET.
    tck_tms(1'b0); tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
    tck_tms(1'b0); tck_tms(1'b0);
    repeat (5) tck_tms(1'b1);
    repeat (8) @(negedge clk);
    check("tms5_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("tms5_instruction", 64'(instruction), 64'(RESET_INST));
    tck_tms(1'b0);

    // 32-bit DR read straight after reset with tdi=0.
    do_dr("reset_dr32", 32, 64'd0, -1, t64);
`ifdef JTAG_TAP_IDCODE_EN
    check("idcode_value", 64'(t64[31:0]), 64'(DEVICE_ID));
`endif

    // Table-driven IR/DR vectors.
    for (int v = 0; v < 5; v++) begin
      do_ir($sformatf("vec%0d", v), vecs[v].ir_in, -1, t4);
      check($sformatf("vec%0d_tbl_ir_tdo", v), 64'(t4), 64'(vecs[v].exp_ir_tdo));
      check($sformatf("vec%0d_tbl_instruction", v), 64'(instruction), 64'(vecs[v].ir_in));
      do_dr($sformatf("vec%0d", v), vecs[v].len, 64'(vecs[v].dr_tdi), -1, t64);
      check($sformatf("vec%0d_tbl_dr_tdo", v), t64 & len_mask(vecs[v].len), 64'(vecs[v].exp_dr_tdo));
    end

    // PAUSE detours must leave shift contents intact.
    do_ir("pause_ir", 4'h3, 1, t4);
    do_dr("pause_user", 8, 64'h5A, 3, t64);
    do_ir("pause_ir_bp", 4'hF, 2, t4);
    do_dr("pause_bypass", 6, 64'h2D, 2, t64);

    // Randomized scans plus random TMS walks ending in five ones.
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0:       ir_val = 4'hF;
        1:       ir_val = 4'h0;
        2:       ir_val = 4'h3;
        default: ir_val = 4'($urandom_range(0, 15));
      endcase
      pause = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
      do_ir($sformatf("rnd%0d", it), ir_val, pause, t4);
      len   = $urandom_range(1, 40);
      pause = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      do_dr($sformatf("rnd%0d", it), len, {32'($urandom), 32'($urandom)}, pause, t64);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 12)) tck_tms($urandom_range(0, 1) != 0);
        repeat (5) tck_tms(1'b1);
        repeat (8) @(negedge clk);
        check($sformatf("rnd%0d_walk_state", it), 64'(dut.state), 64'(TEST_LOGIC_RESET));
        check($sformatf("rnd%0d_walk_instruction", it), 64'(instruction), 64'(RESET_INST));
        m_inst = RESET_INST;
        tck_tms(1'b0);
      end
    end

    // trst during SHIFT_DR after three bits aborts without an update.
    do_ir("trst_setup", 4'h3, -1, t4);
    tck_tms(1'b1); tck_tms(1'b0); tck_tms(1'b0);
    repeat (3) tck_tms(1'b0);
    c0 = n_cap; u0 = n_upd;
    jtag_trst = 1'b1;
    repeat (6) @(negedge clk);
    jtag_trst = 1'b0;
    repeat (6) @(negedge clk);
    check("trst_state", 64'(dut.state), 64'(TEST_LOGIC_RESET));
    check("trst_instruction", 64'(instruction), 64'(RESET_INST));
    check("trst_tdo", 64'(jtag_tdo), 64'd0);
    tck_tms(1'b0);
    repeat (8) @(negedge clk);
    check("trst_no_update", 64'(n_upd - u0), 64'd0);
    check("trst_no_capture", 64'(n_cap - c0), 64'd0);
    m_inst = RESET_INST;
    do_dr("post_trst", 10, 64'h3A5, -1, t64);

    // Strobe shape over the whole run.
    check("strobe_exclusive", 64'(n_excl), 64'd0);
    check("strobe_one_clk", 64'(n_wide), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

Interface
REQ-001 Parameters SHALL be: IR_WIDTH, 4, instruction register width; JTAG_ID, 32'h4d20dffb, IDCODE value; IDCODE_INST, 4'h0, IDCODE opcode.
REQ-002 Ports SHALL be (clock and reset first; reset is asynchronous and active-high; clock is clk):
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- jtag_tck  input  1  host test clock, asynchronous to clk.
- jtag_tms  input  1  mode select.
- jtag_tdi  input  1  serial data into TAP.
- jtag_trst  input  1  test reset, active-high.
- jtag_tdo  output  1  serial data out of TAP.
- instruction  output  IR_WIDTH  current latched instruction.
- capture_dr  output  1  one-clk pulse on Capture-DR, user instruction.
- shift_dr  output  1  one-clk pulse per Shift-DR tck rising edge, user instruction.
- update_dr  output  1  one-clk pulse on Update-DR, user instruction.
- data_shift_in  output  1  tdi bit valid with shift_dr.
- data_shift_out  input  1  user DR LSB, driven to tdo.

Function
REQ-003 tck, tms, tdi and trst SHALL pass through a 2-flop synchronizer; tck rising/falling edges are detected in clk domain.
REQ-004 Each detected tck rising edge SHALL advance the 16-state TAP FSM per IEEE 1149.1 using synchronized tms.
- Latency: 3 clk from pin edge to state update.
- Supported tck phase: high and low each >= 4 clk.
REQ-005 FSM states SHALL be TEST_LOGIC_RESET, IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the six IR equivalents plus SELECT_IR.
REQ-006 Five consecutive tck rising edges with tms=1 SHALL reach TEST_LOGIC_RESET from any state.
REQ-007 In TEST_LOGIC_RESET, instruction SHALL be IDCODE_INST.
REQ-008 CAPTURE_IR SHALL load the IR shift register with {zeros, 2'b01}.
REQ-009 SHIFT_IR SHALL shift right: tdi enters the MSB, LSB is exported.
REQ-010 UPDATE_IR SHALL copy the shift register to instruction.
REQ-011 DR selection SHALL be by latched instruction:
- all-ones: 1-bit BYPASS, captures 0.
- IDCODE_INST: 32-bit IDCODE, captures JTAG_ID.
- otherwise: user DR.
REQ-012 SHIFT_DR on BYPASS/IDCODE SHALL shift right with tdi into the MSB.
REQ-013 On detected tck falling edge, tdo SHALL update:
- IR LSB in SHIFT_IR.
- selected DR LSB (data_shift_out for user) in SHIFT_DR.
- otherwise held.
REQ-014 capture_dr, shift_dr and update_dr SHALL each be exactly one clk wide, asserted only for user instructions, and mutually exclusive.
REQ-015 PAUSE states SHALL hold all shift registers unchanged for any number of tck cycles.
REQ-016 Exit from SHIFT_xR SHALL shift the final bit on that same tck edge.
- A shift of N bits requires N rising edges in SHIFT_xR, the last with tms=1.

Reset
REQ-017 reset or synchronized trst SHALL force TEST_LOGIC_RESET, instruction=IDCODE_INST, jtag_tdo=0, and all pulses=0.
REQ-018 trst mid-operation SHALL abort with no update_dr pulse and no instruction change other than the reset value.

Configuration
REQ-019 Macro JTAG_TAP_IDCODE_EN compiles in the IDCODE register:
- Defined: REQ-007 and REQ-011 apply as written.
- Undefined: reset instruction is all-ones (BYPASS); IDCODE_INST selects the user DR; no 32-bit register is built.

Structure
REQ-020 Package jtag_pkg SHALL hold jtag_tap_state_t and the BYPASS/IDCODE opcode constants.
REQ-021 The 2-flop crossing SHALL use the existing synchronizer sub-module, WIDTH=4; the FSM and registers reside in jtag_tap_controller.

Verification
REQ-022 Scenarios the bench SHALL cover:
- Reset, then tms=1 x5 from SHIFT_DR -> state TEST_LOGIC_RESET, instruction=4'h0.
- After reset, 32-bit DR shift with tdi=0 -> tdo reads 0x4d20dffb LSB first.
- IR shift of 4'hF -> tdo reads 4'b0001 LSB first; instruction=4'hF after UPDATE_IR.
- BYPASS, DR shift tdi=1,0,1,1,0 -> tdo=0,1,0,1,1.
- IR=4'h3, 8-bit DR shift tdi=0xA5 -> 8 shift_dr pulses with data_shift_in=1,0,1,0,0,1,0,1; one capture_dr; one update_dr.
- trst asserted in SHIFT_DR after 3 bits -> TEST_LOGIC_RESET, no update_dr, instruction=4'h0.
